// File: rtl/opc3_stream_port.sv
// opc3 bus target bridging CPU loads/stores at BASE_ADDR (DATA) and BASE_ADDR+1 (STATUS)
// to an outbound TX word stream and an inbound RX word stream, each behind a circular FIFO.
module opc3_stream_port #(
  parameter logic [15:0] BASE_ADDR  = 16'hFE00,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        rnw,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   ZERO_CNT = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   ONE_CNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] ZERO_PTR = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [2:0]            DATA_RD  = 3'b101;

  logic        sel_d;
  logic        sel_s;
  logic [2:0]  acc;
  logic [2:0]  acc_prev;
  logic        acc_start;
  logic        data_wr_start;
  logic        stat_wr_start;
  logic        rd_end;

  logic [15:0]           tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr;
  logic [DEPTH_LOG2-1:0] tx_rd;
  logic [DEPTH_LOG2:0]   tx_cnt;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_ovf;

  logic [15:0]           rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr;
  logic [DEPTH_LOG2-1:0] rx_rd;
  logic [DEPTH_LOG2:0]   rx_cnt;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  rx_push;
  logic                  rx_pop;
  logic                  rx_unf;

  logic [15:0]           status;

  assign sel_d     = (address == BASE_ADDR);
  assign sel_s     = (address == (BASE_ADDR + 16'd1));
  assign acc       = {sel_d, sel_s, rnw};
  assign acc_start = (acc != acc_prev);
  assign data_oe   = rnw & (sel_d | sel_s);

  assign data_wr_start = acc_start & sel_d & ~rnw;
  assign stat_wr_start = acc_start & sel_s & ~rnw;
  // A DATA read ends in the first cycle its decode/rnw no longer holds.
  assign rd_end        = (acc_prev == DATA_RD) & (acc != DATA_RD);

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == ZERO_CNT);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == ZERO_CNT);

  assign tx_push  = data_wr_start & ~tx_full;
  assign tx_pop   = ~tx_empty & tx_ready;
  assign rx_push  = rx_valid & ~rx_full;
  assign rx_pop   = rd_end & ~rx_empty;

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rd];
  assign rx_ready = ~rx_full;

  // Status word assembly.
  always_comb begin
    status                      = 16'h0000;
    status[0]                   = tx_full;
    status[1]                   = tx_empty;
    status[2]                   = rx_empty;
    status[3]                   = rx_full;
    status[4]                   = tx_ovf;
    status[5]                   = rx_unf;
    status[8 +: DEPTH_LOG2 + 1] = rx_cnt;
  end

  // Read mux; an empty RX reads as zero rather than stale storage.
  always_comb begin
    data_out = 16'h0000;
    if (rnw && sel_d) begin
      if (rx_empty) begin
        data_out = 16'h0000;
      end else begin
        data_out = rx_mem[rx_rd];
      end
    end else if (rnw && sel_s) begin
      data_out = status;
    end else begin
      data_out = 16'h0000;
    end
  end

  // FIFO storage writes (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (tx_push && !reset) begin
      tx_mem[tx_wr] <= data_in;
    end
    if (rx_push && !reset) begin
      rx_mem[rx_wr] <= rx_data;
    end
  end

  // Access tracking, pointers, occupancy and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_prev <= 3'b000;
      tx_wr    <= ZERO_PTR;
      tx_rd    <= ZERO_PTR;
      tx_cnt   <= ZERO_CNT;
      rx_wr    <= ZERO_PTR;
      rx_rd    <= ZERO_PTR;
      rx_cnt   <= ZERO_CNT;
      tx_ovf   <= 1'b0;
      rx_unf   <= 1'b0;
    end else begin
      acc_prev <= acc;

      if (tx_push) tx_wr <= tx_wr + ONE_PTR;
      if (tx_pop)  tx_rd <= tx_rd + ONE_PTR;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + ONE_CNT;
        2'b01:   tx_cnt <= tx_cnt - ONE_CNT;
        default: tx_cnt <= tx_cnt;
      endcase

      if (rx_push) rx_wr <= rx_wr + ONE_PTR;
      if (rx_pop)  rx_rd <= rx_rd + ONE_PTR;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + ONE_CNT;
        2'b01:   rx_cnt <= rx_cnt - ONE_CNT;
        default: rx_cnt <= rx_cnt;
      endcase

      // A new overflow/underflow in the same edge as a STATUS clear wins.
      if (data_wr_start && tx_full) begin
        tx_ovf <= 1'b1;
      end else if (stat_wr_start) begin
        tx_ovf <= 1'b0;
      end
      if (rd_end && rx_empty) begin
        rx_unf <= 1'b1;
      end else if (stat_wr_start) begin
        rx_unf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_opc3_stream_port.sv
// Directed bench for opc3_stream_port: stimulus queues expected values, a negedge monitor
// pops and compares them, and a TX scoreboard checks every accepted tx word in order.
module tb_opc3_stream_port;

  localparam logic [15:0] BASE = 16'hFE00;
  localparam logic [15:0] STAT = 16'hFE01;
  localparam logic [15:0] IDLE = 16'h0000;

  localparam int K_DOUT = 0;
  localparam int K_OE   = 1;
  localparam int K_TXV  = 2;
  localparam int K_TXD  = 3;
  localparam int K_RXR  = 4;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } chk_t;

  logic        clk;
  logic        reset;
  logic [15:0] address;
  logic        rnw;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  chk_t        chk_q[$];
  logic [15:0] tx_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  opc3_stream_port dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .rnw      (rnw),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      K_DOUT:  return data_out;
      K_OE:    return {15'h0000, data_oe};
      K_TXV:   return {15'h0000, tx_valid};
      K_TXD:   return tx_data;
      K_RXR:   return {15'h0000, rx_ready};
      default: return 16'hFFFF;
    endcase
  endfunction

  // Monitor: compare queued expectations and scoreboard TX handshakes mid-cycle.
  always @(negedge clk) begin : monitor
    chk_t        e;
    logic [15:0] act;
    logic [15:0] want;
    while (chk_q.size() > 0) begin
      e   = chk_q.pop_front();
      act = observe(e.kind);
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      vectors++;
      if (tx_q.size() == 0) begin
        miscompares++;
        $display("FAIL tx_unexpected: got %h expected no transfer at %0t", tx_data, $time);
      end else begin
        want = tx_q.pop_front();
        if (tx_data !== want) begin
          miscompares++;
          $display("FAIL tx_stream: got %h expected %h at %0t", tx_data, want, $time);
        end
      end
    end
  end

  task automatic expect_out(input int kind, input logic [15:0] exp, input string name);
    chk_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    chk_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    address = IDLE;
    rnw     = 1'b1;
    tick();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] v, input int n);
    address = a;
    rnw     = 1'b0;
    data_in = v;
    repeat (n) tick();
    idle();
  endtask

  task automatic read_status(input logic [15:0] exp, input string name);
    address = STAT;
    rnw     = 1'b1;
    expect_out(K_DOUT, exp, name);
    expect_out(K_OE, 16'h0001, "status_oe");
    tick();
    idle();
  endtask

  task automatic read_data(input logic [15:0] exp, input int n, input string name);
    address = BASE;
    rnw     = 1'b1;
    for (int c = 0; c < n; c++) begin
      expect_out(K_DOUT, exp, name);
      tick();
    end
    idle();
  endtask

  task automatic rx_send(input logic [15:0] v);
    rx_data  = v;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    address  = IDLE;
    rnw      = 1'b1;
    data_in  = 16'h0000;
    tx_ready = 1'b0;
    rx_data  = 16'h0000;
    rx_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    expect_out(K_TXV, 16'h0000, "reset_tx_valid");
    expect_out(K_RXR, 16'h0001, "reset_rx_ready");
    expect_out(K_OE,  16'h0000, "idle_oe");
    expect_out(K_DOUT, 16'h0000, "idle_dout");
    tick();
    read_status(16'h0006, "reset_status");

    // Two 2-cycle writes push exactly two words
    cpu_write(BASE, 16'h1234, 2);
    tx_q.push_back(16'h1234);
    cpu_write(BASE, 16'hABCD, 2);
    tx_q.push_back(16'hABCD);
    expect_out(K_TXV, 16'h0001, "tx_valid_after_writes");
    expect_out(K_TXD, 16'h1234, "tx_head_first");
    tick();
    read_status(16'h0004, "status_tx_nonempty");
    tx_ready = 1'b1;
    tick();
    expect_out(K_TXD, 16'hABCD, "tx_head_second");
    tick();
    tx_ready = 1'b0;
    expect_out(K_TXV, 16'h0000, "tx_drained_after_two");
    tick();

    // Fill TX, overflow with a 17th word, clear the sticky flag
    for (int i = 0; i < 16; i++) begin
      cpu_write(BASE, 16'h5000 + 16'(i), 2);
      tx_q.push_back(16'h5000 + 16'(i));
    end
    cpu_write(BASE, 16'hDEAD, 2);
    read_status(16'h0015, "status_tx_full_ovf");
    cpu_write(STAT, 16'hFFFF, 2);
    read_status(16'h0005, "status_ovf_cleared");
    tx_ready = 1'b1;
    repeat (17) tick();
    tx_ready = 1'b0;
    expect_out(K_TXV, 16'h0000, "tx_drained_after_fill");
    tick();
    read_status(16'h0006, "status_tx_drained");

    // Fill RX from the stream, then a 3-cycle read pops once
    for (int i = 1; i <= 16; i++) rx_send(16'(i));
    expect_out(K_RXR, 16'h0000, "rx_ready_full");
    tick();
    read_status(16'h100A, "status_rx_full");
    read_data(16'h0001, 3, "rx_read_first");
    expect_out(K_RXR, 16'h0001, "rx_ready_after_pop");
    tick();
    read_status(16'h0F02, "status_rx_15");
    for (int i = 2; i <= 16; i++) read_data(16'(i), 1, "rx_read_seq");
    read_status(16'h0006, "status_rx_drained");

    // Underflow read, then a pushed word is read back intact
    read_data(16'h0000, 2, "rx_read_empty");
    read_status(16'h0026, "status_rx_unf");
    rx_send(16'h7777);
    read_data(16'h7777, 1, "rx_read_after_unf");
    read_status(16'h0026, "status_unf_sticky");
    cpu_write(STAT, 16'h0000, 1);
    read_status(16'h0006, "status_unf_cleared");

    // Reset in the middle of a DATA read with 5 words queued
    read_data(16'h0000, 1, "rx_read_empty_again");
    for (int i = 1; i <= 5; i++) rx_send(16'h0A00 + 16'(i));
    read_status(16'h0522, "status_rx5_unf");
    address = BASE;
    rnw     = 1'b1;
    expect_out(K_DOUT, 16'h0A01, "rx_head_before_reset");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_out(K_DOUT, 16'h0000, "dout_after_reset");
    expect_out(K_RXR,  16'h0001, "rx_ready_after_reset");
    expect_out(K_TXV,  16'h0000, "tx_valid_after_reset");
    tick();
    tick();
    idle();
    read_status(16'h0026, "status_post_reset_unf");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_status(16'h0006, "status_flags_reset");

    tick();
    tick();
    vectors++;
    if (tx_q.size() != 0) begin
      miscompares++;
      $display("FAIL tx_leftover: got %0d words pending expected 0", tx_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
